// File: rtl/shiftrows_pipe.sv
// rtl/shiftrows_pipe.sv - elastic AES ShiftRows/InvShiftRows stage with STAGES-deep valid/ready pipeline
// Optional output-transfer counter o_blk_cnt enabled by defining SHIFTROWS_PIPE_CNT_EN.
module shiftrows_pipe #(
  parameter int NB     = 4,
  parameter int WORD   = 8,
  parameter int STAGES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic                   i_inv,
  input  logic [4*NB*WORD-1:0]   i_block,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic                   o_inv,
  output logic [4*NB*WORD-1:0]   o_block
`ifdef SHIFTROWS_PIPE_CNT_EN
  ,
  output logic [31:0]            o_blk_cnt
`endif
);

  localparam int NBYTES = 4 * NB;
  localparam int BW     = NBYTES * WORD;

  // Rijndael row offsets: only the 256-bit block widens the shift of rows 2 and 3.
  function automatic int row_shift(input int r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  logic [BW-1:0] fwd_blk;
  logic [BW-1:0] inv_blk;

  for (genvar k = 0; k < NBYTES; k++) begin : g_map
    localparam int R  = k % 4;
    localparam int C  = k / 4;
    localparam int S  = row_shift(R);
    localparam int FK = ((C + S) % NB) * 4 + R;
    localparam int IK = ((C - S + NB) % NB) * 4 + R;
    assign fwd_blk[(NBYTES-k)*WORD-1 -: WORD] = i_block[(NBYTES-FK)*WORD-1 -: WORD];
    assign inv_blk[(NBYTES-k)*WORD-1 -: WORD] = i_block[(NBYTES-IK)*WORD-1 -: WORD];
  end

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] inv;
  logic [BW-1:0]     data [STAGES];

  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] inv_in;
  logic [BW-1:0]     data_in [STAGES];
  logic              stalled;

  // Stage n may load unless it and every stage after it are full while the output is stalled.
  always_comb begin
    stalled = 1'b0;
    for (int n = 0; n < STAGES; n++) begin
      stalled = !o_ready;
      for (int m = n; m < STAGES; m++) stalled = stalled & v[m];
      adv[n] = !stalled;
    end
  end

  always_comb begin
    v_in[0]    = i_valid;
    inv_in[0]  = i_inv;
    data_in[0] = i_inv ? inv_blk : fwd_blk;
    for (int n = 1; n < STAGES; n++) begin
      v_in[n]    = v[n-1];
      inv_in[n]  = inv[n-1];
      data_in[n] = data[n-1];
    end
  end

  // Payload only moves with a valid token, so idle input garbage never enters a stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v   <= '0;
      inv <= '0;
      for (int n = 0; n < STAGES; n++) data[n] <= '0;
    end else begin
      for (int n = 0; n < STAGES; n++) begin
        if (adv[n]) begin
          v[n] <= v_in[n];
          if (v_in[n]) begin
            inv[n]  <= inv_in[n];
            data[n] <= data_in[n];
          end
        end
      end
    end
  end

  assign i_ready = adv[0];
  assign o_valid = v[STAGES-1];
  assign o_inv   = inv[STAGES-1];
  assign o_block = data[STAGES-1];

`ifdef SHIFTROWS_PIPE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     o_blk_cnt <= '0;
    else if (o_valid && o_ready) o_blk_cnt <= o_blk_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_shiftrows_pipe.sv
// tb/tb_shiftrows_pipe.sv - randomized self-checking bench for shiftrows_pipe
module tb_shiftrows_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // a: NB4 S1, b: NB8 S1, c: NB6 S1, d: NB4 S2, e: NB4 S3
  logic a_iv, a_ir, a_ii, a_ov, a_or, a_oi; logic [127:0] a_ib, a_ob;
  logic b_iv, b_ir, b_ii, b_ov, b_or, b_oi; logic [255:0] b_ib, b_ob;
  logic c_iv, c_ir, c_ii, c_ov, c_or, c_oi; logic [191:0] c_ib, c_ob;
  logic d_iv, d_ir, d_ii, d_ov, d_or, d_oi; logic [127:0] d_ib, d_ob;
  logic e_iv, e_ir, e_ii, e_ov, e_or, e_oi; logic [127:0] e_ib, e_ob;
`ifdef SHIFTROWS_PIPE_CNT_EN
  logic [31:0] a_cnt, b_cnt, c_cnt, d_cnt, e_cnt;
`endif

  shiftrows_pipe #(.NB(4), .WORD(8), .STAGES(1)) u_a (
    .clk(clk), .rst(rst), .i_valid(a_iv), .i_ready(a_ir), .i_inv(a_ii), .i_block(a_ib),
    .o_valid(a_ov), .o_ready(a_or), .o_inv(a_oi), .o_block(a_ob)
`ifdef SHIFTROWS_PIPE_CNT_EN
    , .o_blk_cnt(a_cnt)
`endif
  );
  shiftrows_pipe #(.NB(8), .WORD(8), .STAGES(1)) u_b (
    .clk(clk), .rst(rst), .i_valid(b_iv), .i_ready(b_ir), .i_inv(b_ii), .i_block(b_ib),
    .o_valid(b_ov), .o_ready(b_or), .o_inv(b_oi), .o_block(b_ob)
`ifdef SHIFTROWS_PIPE_CNT_EN
    , .o_blk_cnt(b_cnt)
`endif
  );
  shiftrows_pipe #(.NB(6), .WORD(8), .STAGES(1)) u_c (
    .clk(clk), .rst(rst), .i_valid(c_iv), .i_ready(c_ir), .i_inv(c_ii), .i_block(c_ib),
    .o_valid(c_ov), .o_ready(c_or), .o_inv(c_oi), .o_block(c_ob)
`ifdef SHIFTROWS_PIPE_CNT_EN
    , .o_blk_cnt(c_cnt)
`endif
  );
  shiftrows_pipe #(.NB(4), .WORD(8), .STAGES(2)) u_d (
    .clk(clk), .rst(rst), .i_valid(d_iv), .i_ready(d_ir), .i_inv(d_ii), .i_block(d_ib),
    .o_valid(d_ov), .o_ready(d_or), .o_inv(d_oi), .o_block(d_ob)
`ifdef SHIFTROWS_PIPE_CNT_EN
    , .o_blk_cnt(d_cnt)
`endif
  );
  shiftrows_pipe #(.NB(4), .WORD(8), .STAGES(3)) u_e (
    .clk(clk), .rst(rst), .i_valid(e_iv), .i_ready(e_ir), .i_inv(e_ii), .i_block(e_ib),
    .o_valid(e_ov), .o_ready(e_or), .o_inv(e_oi), .o_block(e_ob)
`ifdef SHIFTROWS_PIPE_CNT_EN
    , .o_blk_cnt(e_cnt)
`endif
  );

  // Reference: gather bytes into a row/column grid and rotate each row by its offset.
  function automatic logic [255:0] ref_sr(input logic [255:0] blk, input int nb, input bit inv);
    logic [7:0]   grid [4][8];
    logic [255:0] res = '0;
    int s, src;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) grid[r][c] = blk[(4*nb-(c*4+r))*8-1 -: 8];
    for (int r = 0; r < 4; r++) begin
      s = (nb == 8 && r > 1) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - s + nb) % nb : (c + s) % nb;
        res[(4*nb-(c*4+r))*8-1 -: 8] = grid[r][src];
      end
    end
    return res;
  endfunction

  function automatic logic [255:0] seq_blk(input int nb);
    logic [255:0] res = '0;
    for (int k = 0; k < 4*nb; k++) res[(4*nb-k)*8-1 -: 8] = k[7:0];
    return res;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL reset_a_ovalid got=%b want=0", a_ov); end
    total++; if (d_ov !== 1'b0 || d_oi !== 1'b0) begin bad++; $display("FAIL reset_d_out got=%b/%b want=0/0", d_ov, d_oi); end
    total++; if (e_ob !== 128'h0) begin bad++; $display("FAIL reset_e_block got=%h want=0", e_ob); end
    total++; if (d_ir !== 1'b1 || e_ir !== 1'b1) begin bad++; $display("FAIL reset_iready got=%b/%b want=1/1", d_ir, e_ir); end
`ifdef SHIFTROWS_PIPE_CNT_EN
    total++; if (d_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", d_cnt); end
`endif
  endtask

  task automatic test_nb4_fwd;
    logic [255:0] s = seq_blk(4);
    @(negedge clk);
    a_ib = s[127:0]; a_ii = 1'b0; a_iv = 1'b1; a_or = 1'b1;
    #1;
    total++; if (a_ir !== 1'b1) begin bad++; $display("FAIL nb4_fwd_iready got=%b want=1", a_ir); end
    @(posedge clk); #1 a_iv = 1'b0;
    @(negedge clk);
    total++; if (a_ov !== 1'b1) begin bad++; $display("FAIL nb4_fwd_valid got=%b want=1", a_ov); end
    total++; if (a_ob !== 128'h00050a0f04090e03080d02070c01060b) begin bad++; $display("FAIL nb4_fwd_block got=%h want=00050a0f04090e03080d02070c01060b", a_ob); end
    total++; if (a_oi !== 1'b0) begin bad++; $display("FAIL nb4_fwd_inv got=%b want=0", a_oi); end
  endtask

  task automatic test_nb4_inv;
    logic [255:0] s = seq_blk(4);
    @(negedge clk);
    a_ib = s[127:0]; a_ii = 1'b1; a_iv = 1'b1; a_or = 1'b1;
    @(posedge clk); #1 a_iv = 1'b0;
    @(negedge clk);
    total++; if (a_ob !== 128'h000d0a0704010e0b0805020f0c090603) begin bad++; $display("FAIL nb4_inv_block got=%h want=000d0a0704010e0b0805020f0c090603", a_ob); end
    total++; if (a_oi !== 1'b1 || a_ov !== 1'b1) begin bad++; $display("FAIL nb4_inv_tag got=%b/%b want=1/1", a_oi, a_ov); end
  endtask

  task automatic test_nb8_round_trip;
    logic [255:0] s = seq_blk(8);
    logic [255:0] fwd;
    @(negedge clk);
    b_ib = s; b_ii = 1'b0; b_iv = 1'b1; b_or = 1'b1;
    @(posedge clk); #1 b_iv = 1'b0;
    @(negedge clk);
    fwd = b_ob;
    total++; if (b_ob[255:224] !== 32'h00050e13) begin bad++; $display("FAIL nb8_col0 got=%h want=00050e13", b_ob[255:224]); end
    total++; if (b_ob !== ref_sr(s, 8, 1'b0)) begin bad++; $display("FAIL nb8_fwd got=%h want=%h", b_ob, ref_sr(s, 8, 1'b0)); end
    b_ib = fwd; b_ii = 1'b1; b_iv = 1'b1;
    @(posedge clk); #1 b_iv = 1'b0;
    @(negedge clk);
    total++; if (b_ob !== s || b_oi !== 1'b1) begin bad++; $display("FAIL nb8_round_trip got=%h/%b want=%h/1", b_ob, b_oi, s); end
  endtask

  task automatic test_nb6_round_trip;
    logic [255:0] s = seq_blk(6);
    logic [255:0] want = ref_sr(s, 6, 1'b0);
    logic [191:0] fwd;
    @(negedge clk);
    c_ib = s[191:0]; c_ii = 1'b0; c_iv = 1'b1; c_or = 1'b1;
    @(posedge clk); #1 c_iv = 1'b0;
    @(negedge clk);
    fwd = c_ob;
    total++; if (c_ob !== want[191:0]) begin bad++; $display("FAIL nb6_fwd got=%h want=%h", c_ob, want[191:0]); end
    c_ib = fwd; c_ii = 1'b1; c_iv = 1'b1;
    @(posedge clk); #1 c_iv = 1'b0;
    @(negedge clk);
    total++; if (c_ob !== s[191:0] || c_oi !== 1'b1) begin bad++; $display("FAIL nb6_round_trip got=%h/%b want=%h/1", c_ob, c_oi, s[191:0]); end
  endtask

  task automatic test_random_backpressure;
    logic [128:0] q [$];
    logic [128:0] head;
    logic [255:0] t;
    logic exp_rdy;
    int acc = 0, got = 0, cyc = 0, rdy_err = 0, data_err = 0;
    while ((acc < 200 || q.size() > 0) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      d_iv = (acc < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
      d_ib = {$urandom, $urandom, $urandom, $urandom};
      d_ii = 1'($urandom_range(0, 1));
      d_or = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = !(q.size() == 2 && !d_or);
      if (d_ir !== exp_rdy && rdy_err < 5) begin
        rdy_err++;
        $display("FAIL rand_iready cycle=%0d got=%b want=%b", cyc, d_ir, exp_rdy);
      end
      if (d_ov && d_or) begin
        if (q.size() == 0) begin
          data_err++;
          $display("FAIL rand_spurious cycle=%0d got=%h want=none", cyc, d_ob);
        end else begin
          head = q.pop_front();
          got++;
          if ({d_oi, d_ob} !== head) begin
            data_err++;
            if (data_err < 5) $display("FAIL rand_data cycle=%0d got=%b/%h want=%b/%h", cyc, d_oi, d_ob, head[128], head[127:0]);
          end
        end
      end
      if (d_iv && d_ir) begin
        t = ref_sr({128'h0, d_ib}, 4, d_ii);
        q.push_back({d_ii, t[127:0]});
        acc++;
      end
    end
    d_iv = 1'b0; d_or = 1'b0;
    total++; if (rdy_err != 0) begin bad++; $display("FAIL rand_iready_total got=%0d want=0", rdy_err); end
    total++; if (data_err != 0) begin bad++; $display("FAIL rand_data_total got=%0d want=0", data_err); end
    total++; if (acc != 200 || got != 200) begin bad++; $display("FAIL rand_count got=%0d/%0d want=200/200", acc, got); end
  endtask

  task automatic test_full_stall;
    logic [128:0] exp [$];
    logic [255:0] t;
    logic [127:0] snap;
    int acc = 0, unstable = 0;
    e_or = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e_ib = {$urandom, $urandom, $urandom, $urandom};
      e_ii = 1'($urandom_range(0, 1));
      e_iv = 1'b1;
      #1;
      if (e_ir) begin
        t = ref_sr({128'h0, e_ib}, 4, e_ii);
        exp.push_back({e_ii, t[127:0]});
        acc++;
      end
    end
    @(negedge clk);
    e_iv = 1'b0;
    #1;
    total++; if (acc != 3) begin bad++; $display("FAIL full_accepted got=%0d want=3", acc); end
    total++; if (e_ir !== 1'b0 || e_ov !== 1'b1) begin bad++; $display("FAIL full_flags got=%b/%b want=0/1", e_ir, e_ov); end
    snap = e_ob;
    repeat (3) begin
      @(negedge clk); #1;
      if (e_ob !== snap || e_ov !== 1'b1) unstable++;
    end
    total++; if (unstable != 0) begin bad++; $display("FAIL full_stable got=%0d want=0", unstable); end
    if (exp.size() < 3) return;
    @(negedge clk);
    e_or = 1'b1;
    #1;
    total++; if (e_ir !== 1'b1) begin bad++; $display("FAIL drain_iready got=%b want=1", e_ir); end
    for (int j = 0; j < 3; j++) begin
      total++;
      if (e_ov !== 1'b1 || {e_oi, e_ob} !== exp[j]) begin
        bad++; $display("FAIL drain_%0d got=%b/%b/%h want=1/%b/%h", j, e_ov, e_oi, e_ob, exp[j][128], exp[j][127:0]);
      end
      @(negedge clk); #1;
    end
    total++; if (e_ov !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", e_ov); end
    e_or = 1'b0;
  endtask

  task automatic test_reset_midstream;
    logic [255:0] t;
    int stale = 0;
    d_or = 1'b0;
    repeat (2) begin
      @(negedge clk);
      d_ib = {$urandom, $urandom, $urandom, $urandom}; d_ii = 1'b1; d_iv = 1'b1;
    end
    @(negedge clk);
    d_iv = 1'b0;
    #1;
    total++; if (d_ov !== 1'b1 || d_ir !== 1'b0) begin bad++; $display("FAIL mid_inflight got=%b/%b want=1/0", d_ov, d_ir); end
    rst = 1'b1;
    #1;
    total++; if (d_ov !== 1'b0 || d_ob !== 128'h0 || d_oi !== 1'b0) begin bad++; $display("FAIL mid_reset got=%b/%h/%b want=0/0/0", d_ov, d_ob, d_oi); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; d_or = 1'b1;
    #1;
    total++; if (d_ir !== 1'b1) begin bad++; $display("FAIL mid_iready got=%b want=1", d_ir); end
`ifdef SHIFTROWS_PIPE_CNT_EN
    total++; if (d_cnt !== 32'd0) begin bad++; $display("FAIL mid_cnt_reset got=%0d want=0", d_cnt); end
`endif
    repeat (3) begin
      @(negedge clk); #1;
      if (d_ov !== 1'b0) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL mid_stale got=%0d want=0", stale); end
    @(negedge clk);
    d_ib = {$urandom, $urandom, $urandom, $urandom}; d_ii = 1'b0; d_iv = 1'b1;
    t = ref_sr({128'h0, d_ib}, 4, 1'b0);
    @(posedge clk); #1 d_iv = 1'b0;
    @(negedge clk);
    total++; if (d_ov !== 1'b0) begin bad++; $display("FAIL mid_latency_early got=%b want=0", d_ov); end
    @(negedge clk);
    total++; if (d_ov !== 1'b1 || d_ob !== t[127:0]) begin bad++; $display("FAIL mid_latency got=%b/%h want=1/%h", d_ov, d_ob, t[127:0]); end
    @(negedge clk);
`ifdef SHIFTROWS_PIPE_CNT_EN
    total++; if (d_cnt !== 32'd1) begin bad++; $display("FAIL mid_cnt_incr got=%0d want=1", d_cnt); end
`endif
    total++; if (d_ov !== 1'b0) begin bad++; $display("FAIL mid_single_out got=%b want=0", d_ov); end
  endtask

  initial begin
    rst = 1'b1;
    {a_iv, a_ii, a_or, b_iv, b_ii, b_or, c_iv, c_ii, c_or} = '0;
    {d_iv, d_ii, d_or, e_iv, e_ii, e_or} = '0;
    a_ib = '0; b_ib = '0; c_ib = '0; d_ib = '0; e_ib = '0;
    test_reset();
    test_nb4_fwd();
    test_nb4_inv();
    test_nb8_round_trip();
    test_nb6_round_trip();
    test_random_backpressure();
    test_full_stall();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shiftrows_pipe.md
Name: shiftrows_pipe

Overview:
Parametrised, elastic ShiftRows / InvShiftRows stage for the AES/Rijndael datapath.
- Supports 4-row states with NB columns (Rijndael NB = 4, 6, 8).
- Per-block encrypt/decrypt mode.
- Configurable pipeline depth with valid/ready backpressure.
- Sits between the SubBytes and MixColumns stages of the round pipeline. Carries a mode tag alongside the data so downstream stages see the matching direction.

Parameters:
NB, 4, number of state columns; legal values 4, 6, 8; block width = 4*NB*WORD.
WORD, 8, bits per state byte.
STAGES, 1, number of register stages; legal 1..4.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
i_valid  input  1  input block valid
i_ready  output  1  stage can accept input this cycle
i_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with i_block
i_block  input  4*NB*WORD  input state
o_valid  output  1  output block valid
o_ready  input  1  downstream accepts output
o_inv  output  1  mode tag travelling with o_block
o_block  output  4*NB*WORD  transformed state

Behaviour:
- Byte map: byte k occupies i_block[(4*NB-k)*WORD-1 -: WORD]; k=0 is the MSB byte. Row r = k mod 4, column c = k div 4 (column-major). o_block uses the same map.
- Row shift offsets s0..s3:
  - NB=4: 0,1,2,3.
  - NB=6: 0,1,2,3.
  - NB=8: 0,1,3,4.
- Forward: out[r][c] = in[r][(c+s_r) mod NB]. Inverse: out[r][c] = in[r][(c−s_r+NB) mod NB].
- The transform is combinational on i_block/i_inv. The result and i_inv are captured into stage 0 on acceptance.
- Acceptance: an input transfer occurs when i_valid && i_ready. An output transfer occurs when o_valid && o_ready.
- Pipeline: each stage n holds v[n], inv[n], data[n].
  - Stage n loads from stage n−1 (or the input, for n=0) when !v[n] || adv[n+1].
  - adv[STAGES] = o_ready.
  - When a stage loads with no incoming valid, v[n] clears.
- i_ready = !v[0] || adv[1] (combinational from downstream state and o_ready; no combinational path from i_valid).
- o_valid = v[STAGES−1], o_block = data[STAGES−1], o_inv = inv[STAGES−1].
- Latency: STAGES cycles from input transfer to o_valid, when not stalled. Throughput: 1 block/cycle while o_ready=1.
- Full condition: all v[] set and o_ready=0. i_ready=0; the stage holds up to STAGES blocks with no loss or reordering.
- Empty condition: all v[]=0. o_valid=0, i_ready=1.
- Simultaneous input and output transfer when full: accepted; occupancy is unchanged.
- o_block/o_inv are stable while o_valid && !o_ready.
- Reset (asserted at any time, including mid-stream):
  - All v[], data[], inv[] clear to 0 immediately.
  - o_valid=0, o_block=0, o_inv=0.
  - i_ready=1 after reset deasserts.
  - In-flight blocks are discarded.
- X on i_block while i_valid=0 must not propagate into any valid stage.

Optional Feature:
SHIFTROWS_PIPE_CNT_EN
- Defined: adds output port o_blk_cnt [31:0]. It counts output transfers, wraps 0xFFFFFFFF→0, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. NB=4, STAGES=1, i_inv=0, bytes 00..0f, o_ready=1 → one cycle later o_block bytes = 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b, o_inv=0.
2. NB=4, i_inv=1, bytes 00..0f → o_block bytes = 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03, o_inv=1.
3. NB=8, i_inv=0, bytes 00..1f → output column 0 = 00 05 0e 13. Then feed the output back with i_inv=1 → bytes 00..1f restored exactly. Repeat the round-trip for NB=6.
4. STAGES=2, 200 random blocks with random i_inv, random i_valid and o_ready each at 50% → outputs match the reference model in order with matching o_inv. i_ready=0 only when both stages are full and o_ready=0. No drops or duplicates.
5. STAGES=3, o_ready held 0, offer 5 blocks → exactly 3 accepted, then i_ready=0. o_block stays stable. Raise o_ready → 3 blocks drain in order, one per cycle, and i_ready returns to 1 in the same cycle.
6. Assert rst for 1 cycle while 2 blocks are in flight → o_valid=0 and o_block=0 immediately, no stale block emitted, next accepted block emerges after STAGES cycles. With SHIFTROWS_PIPE_CNT_EN: o_blk_cnt=0 after reset and increments once per output transfer.
